// File: rtl/neuron_accumulator.sv
// Weighted-sum neuron: collects NUM_INPUTS DATA packets, emits bias + sum(x*w).
// Optional ACC_SATURATE_EN clamps every add to the signed SSUM_WIDTH range.
package neuron_pkg;
    localparam int TYPE_WIDTH  = 2;
    localparam int SEQ_WIDTH   = 4;
    localparam int INPUT_WIDTH = 8;
    localparam int SSUM_WIDTH  = 16;
    localparam logic [TYPE_WIDTH-1:0] DATA   = 2'd1;
    localparam logic [TYPE_WIDTH-1:0] WEIGHT = 2'd2;
    localparam logic [TYPE_WIDTH-1:0] BIAS   = 2'd3;
endpackage

module neuron_accumulator
    import neuron_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int NEURON_ID  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hlt,
    input  logic                   NI_ACC_valid,
    input  logic [TYPE_WIDTH-1:0]  NI_ACC_type,
    input  logic [SEQ_WIDTH-1:0]   NI_ACC_seqNum,
    input  logic [INPUT_WIDTH-1:0] NI_ACC_payload,
    output logic                   ACC_AF_valid,
    output logic [TYPE_WIDTH-1:0]  ACC_AF_type,
    output logic [SEQ_WIDTH-1:0]   ACC_AF_seqNum,
    output logic [SSUM_WIDTH-1:0]  ACC_AF_data
);
    localparam int WEIGHT_WIDTH = INPUT_WIDTH;
    localparam int PW = INPUT_WIDTH + WEIGHT_WIDTH;
    localparam int CW = SEQ_WIDTH + 1;
    localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT
    } state_t;

    state_t state, state_n;

    logic signed [WEIGHT_WIDTH-1:0] weight [NUM_INPUTS];
    logic signed [SSUM_WIDTH-1:0]   bias;
    logic signed [SSUM_WIDTH-1:0]   acc, acc_n;
    logic [CW-1:0]                  count, count_n;
    logic [NUM_INPUTS-1:0]          seen, seen_n;

    logic                  out_valid, out_valid_n;
    logic [TYPE_WIDTH-1:0] out_type, out_type_n;
    logic [SSUM_WIDTH-1:0] out_data, out_data_n;

    logic                   accept;
    logic                   in_range;
    logic [IW-1:0]          idx;
    logic [NUM_INPUTS-1:0]  idx_bit;
    logic                   fresh;
    logic                   data_ok;
    logic                   weight_wr;
    logic                   bias_wr;
    logic signed [PW-1:0]   prod;
    logic signed [SSUM_WIDTH-1:0] prod_ext;
    logic signed [SSUM_WIDTH-1:0] base;
    logic signed [SSUM_WIDTH-1:0] sum;
    logic [CW-1:0]          count_inc;

    function automatic logic signed [SSUM_WIDTH-1:0] acc_add(
        input logic signed [SSUM_WIDTH-1:0] a,
        input logic signed [SSUM_WIDTH-1:0] b
    );
`ifdef ACC_SATURATE_EN
        logic signed [SSUM_WIDTH:0] w;
        w = {a[SSUM_WIDTH-1], a} + {b[SSUM_WIDTH-1], b};
        if (w[SSUM_WIDTH] != w[SSUM_WIDTH-1])
            return w[SSUM_WIDTH] ? {1'b1, {(SSUM_WIDTH-1){1'b0}}}
                                 : {1'b0, {(SSUM_WIDTH-1){1'b1}}};
        return w[SSUM_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    assign accept   = NI_ACC_valid && !hlt;
    assign in_range = {1'b0, NI_ACC_seqNum} < CW'(NUM_INPUTS);
    assign idx      = NI_ACC_seqNum[IW-1:0];
    assign idx_bit  = NUM_INPUTS'(1) << idx;
    assign fresh    = (state != ACCUM);

    // a new frame opens in IDLE or in the EMIT cycle; only ACCUM sees duplicates
    assign data_ok = accept && (NI_ACC_type == DATA) && in_range
                     && (fresh || !(|(seen & idx_bit)));
    assign weight_wr = accept && (NI_ACC_type == WEIGHT) && in_range;
    assign bias_wr   = accept && (NI_ACC_type == BIAS);

    assign prod      = $signed(NI_ACC_payload) * weight[idx];
    assign prod_ext  = SSUM_WIDTH'(prod);
    assign base      = fresh ? bias : acc;
    assign sum       = acc_add(base, prod_ext);
    assign count_inc = fresh ? CW'(1) : count + CW'(1);

    always_comb begin
        state_n = state;
        acc_n   = acc;
        count_n = count;
        seen_n  = seen;
        if (data_ok) begin
            acc_n   = sum;
            count_n = count_inc;
            seen_n  = fresh ? idx_bit : (seen | idx_bit);
            state_n = (count_inc == CW'(NUM_INPUTS)) ? EMIT : ACCUM;
        end else if (state == EMIT) begin
            acc_n   = bias;
            count_n = '0;
            seen_n  = '0;
            state_n = IDLE;
        end
    end

    always_comb begin
        out_valid_n = (state_n == EMIT);
        out_type_n  = out_valid_n ? DATA : '0;
        out_data_n  = out_valid_n ? sum : out_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            bias      <= '0;
            count     <= '0;
            seen      <= '0;
            out_valid <= 1'b0;
            out_type  <= '0;
            out_data  <= '0;
            for (int i = 0; i < NUM_INPUTS; i++)
                weight[i] <= '0;
        end else if (!hlt) begin
            state     <= state_n;
            acc       <= acc_n;
            count     <= count_n;
            seen      <= seen_n;
            out_valid <= out_valid_n;
            out_type  <= out_type_n;
            out_data  <= out_data_n;
            if (weight_wr)
                weight[idx] <= NI_ACC_payload;
            if (bias_wr)
                bias <= SSUM_WIDTH'($signed(NI_ACC_payload));
        end
    end

    assign ACC_AF_valid  = out_valid;
    assign ACC_AF_type   = out_type;
    assign ACC_AF_seqNum = SEQ_WIDTH'(NEURON_ID);
    assign ACC_AF_data   = out_data;

endmodule
